mem_responder: RTL
==================

# mem_responder

Memory-side responder for the core's multicycle request/busy memory protocol. It accepts read or write requests, with a byte, half or word access size, from the control/datapath. It stalls the core through `busy_o` for a configurable access latency, then returns zero-extended read data or commits byte-lane writes into an internal word-organised RAM. Misaligned, out-of-range or conflicting requests raise a sticky `error_o`, which feeds the core's `error_i`.

## Interface
- `MEM_WORDS`, 1024: RAM depth in 32-bit words (power of two).
- `LATENCY`, 2: cycles from request acceptance to data/commit, ≥1.
- `INIT_FILE`, "": optional `$readmemh` image; empty means no initialisation.

Ports:
- `clk_i` in 1: clock.
- `reset_ni` in 1: reset. One clock; reset is asynchronous and active-low.
- `rd_enable_i` in 1: read request, sampled when idle.
- `rd_addr_i` in 32: byte address of read.
- `rd_size_i` in `mem_access_size_t`: read size (BYTE/HALF/WORD).
- `wr_enable_i` in 1: write request, sampled when idle.
- `wr_addr_i` in 32: byte address of write.
- `wr_size_i` in `mem_access_size_t`: write size.
- `wr_data_i` in 32: write data, right-aligned (bits [7:0] for byte, [15:0] for half).
- `busy_o` out 1: access in progress; core must hold.
- `rd_data_o` out 32: read result, zero-extended, right-aligned.
- `error_o` out 1: sticky protocol/alignment error.

## Operation
- States: IDLE, WAIT, ERROR.
- IDLE:
  - Exactly one enable high and the request is legal: capture addr/size/data/kind, load `cnt = LATENCY-1`, go to WAIT.
- Legality checks:
  - HALF needs `addr[0]=0`.
  - WORD needs `addr[1:0]=0`.
  - Word index `addr[31:2]` must be `< MEM_WORDS`.
  - `rd_enable_i` and `wr_enable_i` must not both be high.
  - Any violation: go to ERROR; no RAM access; `error_o` set.
- WAIT:
  - `cnt != 0`: decrement; `busy_o=1`.
  - `cnt == 0`: `busy_o=0`; complete the access; return to IDLE next cycle.
- Read completion:
  - `rd_data_o` registered from RAM word, lane-selected by captured `addr[1:0]`.
  - BYTE: byte `addr[1:0]` into [7:0], upper bits 0.
  - HALF: half `addr[1]` into [15:0], upper bits 0.
  - WORD: whole word.
- Write completion:
  - Data is replicated across lanes; byte enables are derived from size and `addr[1:0]`; the word is updated at the completion edge.
  - `rd_data_o` is unchanged by writes.
- `rd_data_o` holds its value until the next read completes.
- Enables asserted while in WAIT or ERROR are ignored.
- ERROR is absorbing until reset: `busy_o=0`, no RAM access, requests ignored.
- Sign extension is the core's job; this block always zero-extends.

## Timing
- Request accepted at edge E0, i.e. enable high in the IDLE cycle before E0.
- `busy_o` is high in cycles E0..E0+LATENCY-2 and low from the cycle after E0+LATENCY-1.
- Read data is valid in the first cycle `busy_o` is low after acceptance; the core samples it on that cycle's edge.
- `LATENCY=1`: `busy_o` never rises; data is valid the cycle after issue.
- Write commit occurs on the edge ending the last WAIT cycle. A read issued afterwards observes the new data.
- Back-to-back: the next request may be issued the cycle after the completion cycle (IDLE).
- Error: `error_o` rises on the cycle after the illegal request is sampled; `busy_o` stays 0.
- Reset, asynchronous assertion:
  - state IDLE, `busy_o=0`, `rd_data_o=0`, `error_o=0`.
  - A pending write is dropped.
  - RAM contents are not reset.
- Reset deassertion is synchronised externally; the first request is accepted at the first edge after deassertion.
- `busy_o` and `error_o` are decoded from registered state only; no combinational path from inputs.

## Test plan
- Word read, `LATENCY=2`, RAM[4]=0xDEADBEEF, rd addr 0x10 WORD → `busy_o` high 1 cycle, then `rd_data_o=0xDEADBEEF` with `busy_o=0`.
- Sub-word: SB 0xAB to 0x13 into word 0x11223344, then LHU 0x12 → `0x0000AB22`; LBU 0x10 → `0x00000044`; LW 0x10 → `0xAB223344`.
- `LATENCY=1` and `LATENCY=4`: issue LW → `busy_o` high for 0 and 3 cycles respectively; data correct; next request accepted the cycle after completion.
- Misaligned LH 0x21 → no busy, `error_o=1` next cycle and sticky. A following legal LW is ignored; `rd_data_o` unchanged.
- Out-of-range (0x1000 with `MEM_WORDS=1024`) and simultaneous rd+wr enables → each sets `error_o`; RAM is unmodified, checked after reset.
- `reset_ni` low mid-WAIT of an SW 0x55 to 0x8 → outputs reset immediately; read of 0x8 after reset returns the old value; `error_o=0`.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the core's request/busy protocol.
// Accepts a single read or write (byte/half/word) while idle and holds busy_o
// for LATENCY-1 cycles. Reads return right-aligned, zero-extended data.
// Writes commit byte lanes into a word-organised RAM. Illegal requests set
// error_o, and error_o stays set until reset.
//
// Ports:
//   clk_i, reset_ni         clock, asynchronous active-low reset
//   rd_enable_i/addr/size   read request, sampled only in IDLE
//   wr_enable_i/addr/size   write request, sampled only in IDLE
//   wr_data_i               right-aligned write data
//   busy_o                  access in progress; core must hold
//   rd_data_o               last completed read, zero-extended
//   error_o                 sticky protocol/alignment error

package mem_responder_pkg;
  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_access_size_t;
endpackage

module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned LATENCY   = 2,
  parameter              INIT_FILE = ""
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             rd_enable_i,
  input  logic [31:0]      rd_addr_i,
  input  mem_access_size_t rd_size_i,
  input  logic             wr_enable_i,
  input  logic [31:0]      wr_addr_i,
  input  mem_access_size_t wr_size_i,
  input  logic [31:0]      wr_data_i,
  output logic             busy_o,
  output logic [31:0]      rd_data_o,
  output logic             error_o
);

  localparam int unsigned      IDX_W    = $clog2(MEM_WORDS);
  localparam int unsigned      CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERROR} state_t;

  logic [31:0] ram [MEM_WORDS];

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             req_write;
  logic [IDX_W-1:0] req_idx;
  logic [1:0]       req_lo;
  mem_access_size_t req_size;
  logic [31:0]      req_data;
  logic [3:0]       req_be;

  // Legal when naturally aligned and the word index lies inside the RAM.
  function automatic logic is_legal(input logic [31:0] addr, input mem_access_size_t size);
    logic ok;
    ok = ((addr[31:2] >> IDX_W) == '0);
    case (size)
      MEM_BYTE: ;
      MEM_HALF: ok = ok & ~addr[0];
      MEM_WORD: ok = ok & (addr[1:0] == 2'b00);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Alignment is already guaranteed, so one byte-granular shift serves both sub-word sizes.
  function automatic logic [31:0] lane_select(input logic [31:0] word, input logic [1:0] lo,
                                              input mem_access_size_t size);
    logic [31:0] shifted;
    shifted = word >> {lo, 3'b000};
    case (size)
      MEM_BYTE: return {24'h0, shifted[7:0]};
      MEM_HALF: return {16'h0, shifted[15:0]};
      default:  return word;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] lo, input mem_access_size_t size);
    case (size)
      MEM_BYTE: return 4'b0001 << lo;
      MEM_HALF: return 4'b0011 << lo;
      default:  return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [31:0] data, input mem_access_size_t size);
    case (size)
      MEM_BYTE: return {4{data[7:0]}};
      MEM_HALF: return {2{data[15:0]}};
      default:  return data;
    endcase
  endfunction

  logic             rd_ok, wr_ok, req_bad, req_go;
  logic [IDX_W-1:0] ld_idx;
  logic [31:0]      ld_word;

  assign rd_ok   = is_legal(rd_addr_i, rd_size_i);
  assign wr_ok   = is_legal(wr_addr_i, wr_size_i);
  assign req_bad = (rd_enable_i & wr_enable_i) | (rd_enable_i & ~rd_ok) | (wr_enable_i & ~wr_ok);
  assign req_go  = (rd_enable_i ^ wr_enable_i) & ~req_bad;

  // Read data is loaded on the edge that enters the last WAIT cycle. With
  // LATENCY=1 that edge is the acceptance edge, so the word comes straight
  // from the request port while idle.
  assign ld_idx  = (state == S_IDLE) ? rd_addr_i[IDX_W+1:2] : req_idx;
  assign ld_word = ram[ld_idx];

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state     <= S_IDLE;
      cnt       <= '0;
      req_write <= 1'b0;
      req_idx   <= '0;
      req_lo    <= '0;
      req_size  <= MEM_BYTE;
      req_data  <= '0;
      req_be    <= '0;
      busy_o    <= 1'b0;
      rd_data_o <= '0;
      error_o   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_bad) begin
            state   <= S_ERROR;
            error_o <= 1'b1;
          end else if (req_go) begin
            state     <= S_WAIT;
            cnt       <= CNT_LOAD;
            busy_o    <= (LATENCY > 1);
            req_write <= wr_enable_i;
            req_idx   <= wr_enable_i ? wr_addr_i[IDX_W+1:2] : rd_addr_i[IDX_W+1:2];
            req_lo    <= wr_enable_i ? wr_addr_i[1:0] : rd_addr_i[1:0];
            req_size  <= wr_enable_i ? wr_size_i : rd_size_i;
            req_data  <= replicate(wr_data_i, wr_size_i);
            req_be    <= byte_enables(wr_addr_i[1:0], wr_size_i);
            if (LATENCY == 1 && rd_enable_i)
              rd_data_o <= lane_select(ld_word, rd_addr_i[1:0], rd_size_i);
          end
        end
        S_WAIT: begin
          if (cnt != '0) begin
            cnt    <= cnt - 1'b1;
            busy_o <= (cnt != CNT_ONE);
            if (cnt == CNT_ONE && !req_write)
              rd_data_o <= lane_select(ld_word, req_lo, req_size);
          end else begin
            state <= S_IDLE;
          end
        end
        default: ;  // ERROR absorbs everything until reset
      endcase
    end
  end

  // NOTE: the RAM array deliberately has no reset; contents survive reset and
  // a reset-free block lets the array map onto block RAM. A pending write is
  // still dropped because its enable comes from the reset state registers.
  always_ff @(posedge clk_i) begin
    if (state == S_WAIT && cnt == '0 && req_write) begin
      for (int i = 0; i < 4; i++) begin
        if (req_be[i]) ram[req_idx][8*i +: 8] <= req_data[8*i +: 8];
      end
    end
  end

endmodule
